alu_result_uart_tx: RTL and testbench



---
 rtl/alu_result_uart_tx.sv | 143 ++++++++++++++
 tb/tb_alu_result_uart_tx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_uart_tx.sv
// alu_result_uart_tx
// Captures the ALU result and carry on request and sends them back to the
// host as two UART 8N1 frames on a single TX line:
//   1. the result byte;
//   2. a status byte, {7'b0, carry}.
// The two frames go out back to back with no idle gap between them.
module alu_result_uart_tx #(
    parameter int NB_DATA      = 8,    // must be 8: one UART byte per result
    parameter int CLKS_PER_BIT = 868   // clocks per UART bit, >= 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_res,
    input  logic               i_carry,
    input  logic               i_valid,
    output logic               o_ready,
    output logic               o_tx,
    output logic               o_done
);

    // Baud counter runs 0..CLKS_PER_BIT-1, so $clog2 bits always suffice.
    localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             r_state,    w_state_next;
    logic [BW-1:0]      r_baud,     w_baud_next;
    logic [2:0]         r_bit_idx,  w_bit_idx_next;
    logic               r_byte_idx, w_byte_idx_next;
    logic [NB_DATA-1:0] r_shift,    w_shift_next;   // byte on the wire, LSB out first
    logic [NB_DATA-1:0] r_status,   w_status_next;  // second byte, latched at accept
    logic               r_done,     w_done_next;

    logic w_bit_end;
    assign w_bit_end = (r_baud == BAUD_LAST);

    // State register: reset abandons any frame in flight and returns the line high.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= 1'b0;
            r_shift    <= '0;
            r_status   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_baud     <= w_baud_next;
            r_bit_idx  <= w_bit_idx_next;
            r_byte_idx <= w_byte_idx_next;
            r_shift    <= w_shift_next;
            r_status   <= w_status_next;
            r_done     <= w_done_next;
        end
    end

    // Next-state logic: each bit lasts CLKS_PER_BIT cycles; advance on the last count.
    always_comb begin
        w_state_next    = r_state;
        w_baud_next     = r_baud;
        w_bit_idx_next  = r_bit_idx;
        w_byte_idx_next = r_byte_idx;
        w_shift_next    = r_shift;
        w_status_next   = r_status;
        w_done_next     = 1'b0;

        case (r_state)
            IDLE: begin
                // Inputs are sampled only here, so later changes never reach the wire.
                if (i_valid) begin
                    w_shift_next    = i_res;
                    w_status_next   = NB_DATA'(i_carry);
                    w_byte_idx_next = 1'b0;
                    w_bit_idx_next  = '0;
                    w_baud_next     = '0;
                    w_state_next    = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_baud_next    = '0;
                    w_bit_idx_next = '0;
                    w_state_next   = DATA;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_baud_next  = '0;
                    w_shift_next = r_shift >> 1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_baud_next = '0;
                    if (!r_byte_idx) begin
                        // Status byte follows immediately, no idle gap.
                        w_byte_idx_next = 1'b1;
                        w_shift_next    = r_status;
                        w_state_next    = START;
                    end else begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Line driver: low for start, current LSB for data, high for stop and idle.
    always_comb begin
        o_tx = 1'b1;
        case (r_state)
            START:   o_tx = 1'b0;
            DATA:    o_tx = r_shift[0];
            default: o_tx = 1'b1;
        endcase
    end

    assign o_ready = (r_state == IDLE);
    assign o_done  = r_done;

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Bench for alu_result_uart_tx.
// Two instances run side by side:
//   - CLKS_PER_BIT=4, the main instance;
//   - CLKS_PER_BIT=2, the baud-parameter instance.
// The expected line waveform is built from the 8N1 framing rules.
module tb_alu_result_uart_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] res4, res2;
    logic       carry4, carry2, valid4, valid2;
    logic       ready4, tx4, done4;
    logic       ready2, tx2, done2;

    int n_total = 0;
    int n_pass  = 0;

    bit exp_q[$];

    always #5 clk = ~clk;

    alu_result_uart_tx #(.NB_DATA(8), .CLKS_PER_BIT(4)) dut4 (
        .i_clk  (clk),
        .i_reset(reset),
        .i_res  (res4),
        .i_carry(carry4),
        .i_valid(valid4),
        .o_ready(ready4),
        .o_tx   (tx4),
        .o_done (done4)
    );

    alu_result_uart_tx #(.NB_DATA(8), .CLKS_PER_BIT(2)) dut2 (
        .i_clk  (clk),
        .i_reset(reset),
        .i_res  (res2),
        .i_carry(carry2),
        .i_valid(valid2),
        .o_ready(ready2),
        .o_tx   (tx2),
        .o_done (done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Move to just after the next rising edge, where outputs are sampled and inputs driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference line activity for one capture: two 8N1 frames, each bit repeated cpb times.
    task automatic build(input int cpb, input logic [7:0] b0, input logic [7:0] b1);
        logic [7:0] bytes [2];
        exp_q.delete();
        bytes[0] = b0;
        bytes[1] = b1;
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < cpb; c++) exp_q.push_back(1'b0);
            for (int i = 0; i < 8; i++)
                for (int c = 0; c < cpb; c++) exp_q.push_back(((bytes[b] >> i) & 8'd1) != 0);
            for (int c = 0; c < cpb; c++) exp_q.push_back(1'b1);
        end
    endtask

    // Called on the sample just after the accept edge.
    // Checks all 20*cpb line cycles, then the o_done cycle.
    // poke_at >= 0 issues an ignored request with new data mid-frame (main instance only).
    task automatic run_frame(input bit sel2, input int cpb, input logic [7:0] b0,
                             input logic [7:0] b1, input int poke_at, input string tag);
        build(cpb, b0, b1);
        for (int k = 0; k < 20 * cpb; k++) begin
            chk({tag, "_tx"},    sel2 ? tx2 : tx4,       exp_q[k]);
            chk({tag, "_ready"}, sel2 ? ready2 : ready4, 0);
            chk({tag, "_done"},  sel2 ? done2 : done4,   0);
            if (poke_at >= 0 && k == poke_at) begin
                valid4 = 1'b1;
                res4   = 8'hFF;
                carry4 = 1'b0;
            end else if (poke_at >= 0 && k == poke_at + 1) begin
                valid4 = 1'b0;
                res4   = 8'h12;
            end
            step();
        end
        chk({tag, "_done_pulse"}, sel2 ? done2 : done4,   1);
        chk({tag, "_done_ready"}, sel2 ? ready2 : ready4, 1);
        chk({tag, "_done_tx"},    sel2 ? tx2 : tx4,       1);
    endtask

    initial begin
        logic [7:0] r;
        logic       c;

        reset  = 1'b1;
        valid4 = 1'b1;
        valid2 = 1'b1;
        res4   = 8'h00;
        carry4 = 1'b0;
        res2   = 8'h00;
        carry2 = 1'b0;

        // Reset held 3 cycles with a pending request: nothing may start.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_tx",    tx4,    1);
            chk("rst_ready", ready4, 1);
            chk("rst_done",  done4,  0);
            chk("rst_tx2",   tx2,    1);
        end
        valid4 = 1'b0;
        valid2 = 1'b0;
        reset  = 1'b0;
        step();
        chk("idle_tx",    tx4,    1);
        chk("idle_ready", ready4, 1);

        // Basic frame; a request with different data mid-frame must be ignored.
        res4   = 8'hA5;
        carry4 = 1'b1;
        valid4 = 1'b1;
        step();
        valid4 = 1'b0;
        run_frame(1'b0, 4, 8'hA5, 8'h01, 10, "basic");
        for (int i = 0; i < 3; i++) begin
            step();
            chk("after_basic_tx",    tx4,    1);
            chk("after_basic_ready", ready4, 1);
            chk("after_basic_done",  done4,  0);
        end

        // Random captures.
        for (int n = 0; n < 4; n++) begin
            r      = 8'($urandom);
            c      = 1'($urandom_range(0, 1));
            res4   = r;
            carry4 = c;
            valid4 = 1'b1;
            step();
            valid4 = 1'b0;
            res4   = ~r;
            carry4 = ~c;
            run_frame(1'b0, 4, r, {7'b0, c}, -1, "rand");
            step();
        end

        // Back-to-back: one idle-high cycle (the o_done cycle) between frames.
        res4   = 8'h00;
        carry4 = 1'b0;
        valid4 = 1'b1;
        step();
        for (int n = 0; n < 3; n++) begin
            run_frame(1'b0, 4, 8'h00, 8'h00, -1, "b2b");
            if (n == 2) valid4 = 1'b0;
            step();
        end
        chk("b2b_end_tx",    tx4,    1);
        chk("b2b_end_ready", ready4, 1);

        // Reset during bit 3 of the result byte.
        r      = 8'($urandom);
        res4   = r;
        carry4 = 1'b1;
        valid4 = 1'b1;
        step();
        valid4 = 1'b0;
        build(4, r, 8'h01);
        for (int k = 0; k < 18; k++) begin
            chk("pre_rst_tx", tx4, exp_q[k]);
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_tx",    tx4,    1);
        chk("midrst_ready", ready4, 1);
        chk("midrst_done",  done4,  0);
        for (int i = 0; i < 90; i++) begin
            step();
            chk("post_rst_tx",   tx4,   1);
            chk("post_rst_done", done4, 0);
        end
        res4   = 8'h3C;
        carry4 = 1'b0;
        valid4 = 1'b1;
        step();
        valid4 = 1'b0;
        run_frame(1'b0, 4, 8'h3C, 8'h00, -1, "after_rst");

        // Baud parameter: two clocks per bit, 40-cycle capture.
        res2   = 8'h81;
        carry2 = 1'b1;
        valid2 = 1'b1;
        step();
        valid2 = 1'b0;
        run_frame(1'b1, 2, 8'h81, 8'h01, -1, "cpb2");
        step();
        chk("cpb2_end_done", done2, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
